// File: rtl/bmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bmem_responder_pkg
// Brief    : Shared burst-interface constants and the queued request record.
// Revision : 1.0
// ============================================================================
package bmem_responder_pkg;

    localparam int BMEM_BURST_LEN = 4;
    localparam int BMEM_LINE_BITS = 256;
    localparam int BMEM_WORD_BITS = 64;

    typedef struct packed {
        logic                      is_write;
        logic [26:0]               line;
        logic [BMEM_LINE_BITS-1:0] data;
        logic [7:0]                cnt;
    } bmem_req_t;

endpackage
`default_nettype wire

// File: rtl/bmem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bmem_req_fifo
// Brief    : In-order circular request queue; every entry's latency count
//            decrements each cycle, saturating at zero.
// Revision : 1.0
// ============================================================================
module bmem_req_fifo
    import bmem_responder_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  bmem_req_t i_push_entry,
    input  logic      i_pop,
    output bmem_req_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int c_ptr_w = $clog2(QDEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(QDEPTH);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    bmem_req_t          r_entries [QDEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_full_cnt);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_entries[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Stale slots also count down; harmless because only live slots are read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (r_entries[i].cnt != 8'd0)
                r_entries[i].cnt <= r_entries[i].cnt - 8'd1;
        end
        if (w_do_push)
            r_entries[r_wr_ptr] <= i_push_entry;
    end

endmodule
`default_nettype wire

// File: rtl/bmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : bmem_responder
// Brief    : Memory-side bmem endpoint: collects write bursts, queues requests
//            in order and replays reads as 4-beat bursts after a fixed latency.
// Revision : 1.0
// ============================================================================
module bmem_responder
    import bmem_responder_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int READ_LAT  = 8,
    parameter int MEM_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid
);

    localparam int c_idx_w  = $clog2(MEM_WORDS);
    localparam int c_line_w = c_idx_w - 2;

    localparam logic [1:0] c_last_beat = 2'(BMEM_BURST_LEN - 1);

    localparam logic [0:0] c_wc_idle    = 1'b0;
    localparam logic [0:0] c_wc_collect = 1'b1;

    localparam logic [0:0] c_svc_idle  = 1'b0;
    localparam logic [0:0] c_svc_burst = 1'b1;

    logic [BMEM_WORD_BITS-1:0] r_mem [MEM_WORDS];

    logic                       r_up;
    logic [0:0]                 r_wc_state;
    logic [0:0]                 w_wc_state_nxt;
    logic [1:0]                 r_wc_beat;
    logic [26:0]                r_wc_line;
    logic [3*BMEM_WORD_BITS-1:0] r_wc_buf;
    logic                       w_wc_push;

    logic [0:0]   r_svc_state;
    logic [0:0]   w_svc_state_nxt;
    logic [1:0]   r_beat;
    logic [1:0]   w_beat_nxt;
    logic         w_commit;
    logic         w_pop;
    logic [c_idx_w-1:0] w_rd_idx;

    logic      w_full;
    logic      w_empty;
    logic      w_acc_wr;
    logic      w_acc_rd;
    logic      w_push;
    bmem_req_t w_push_entry;
    bmem_req_t w_head;
    logic      w_unused_addr;

    assign w_unused_addr = ^bmem_addr[4:0];

    // Ready waits one edge after reset and stays low for the whole collect.
    assign bmem_ready = r_up & ~w_full & (r_wc_state == c_wc_idle);
    assign w_acc_wr   = bmem_ready & bmem_write;
    assign w_acc_rd   = bmem_ready & bmem_read & ~bmem_write;
    assign w_push     = w_acc_rd | w_wc_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_up <= 1'b0;
        else     r_up <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wc_state <= c_wc_idle;
        else     r_wc_state <= w_wc_state_nxt;
    end

    always_comb begin
        w_wc_state_nxt = r_wc_state;
        case (r_wc_state)
            c_wc_idle:    if (w_acc_wr) w_wc_state_nxt = c_wc_collect;
            c_wc_collect: if (!bmem_write || r_wc_beat == c_last_beat)
                              w_wc_state_nxt = c_wc_idle;
            default:      w_wc_state_nxt = c_wc_idle;
        endcase
    end

    always_comb begin
        w_wc_push = (r_wc_state == c_wc_collect) && bmem_write && (r_wc_beat == c_last_beat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wc_beat <= '0;
            r_wc_line <= '0;
            r_wc_buf  <= '0;
        end else if (w_acc_wr) begin
            r_wc_beat      <= 2'd1;
            r_wc_line      <= bmem_addr[31:5];
            r_wc_buf[63:0] <= bmem_wdata;
        end else if (r_wc_state == c_wc_collect && bmem_write) begin
            r_wc_beat <= r_wc_beat + 2'd1;
            case (r_wc_beat)
                2'd1:    r_wc_buf[127:64]  <= bmem_wdata;
                2'd2:    r_wc_buf[191:128] <= bmem_wdata;
                default: r_wc_buf          <= r_wc_buf;
            endcase
        end
    end

    always_comb begin
        w_push_entry = '0;
        if (w_wc_push) begin
            w_push_entry.is_write = 1'b1;
            w_push_entry.line     = r_wc_line;
            w_push_entry.data     = {bmem_wdata, r_wc_buf};
        end else begin
            w_push_entry.line = bmem_addr[31:5];
            w_push_entry.cnt  = 8'(READ_LAT - 1);
        end
    end

    bmem_req_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_svc_state <= c_svc_idle;
            r_beat      <= '0;
        end else begin
            r_svc_state <= w_svc_state_nxt;
            r_beat      <= w_beat_nxt;
        end
    end

    always_comb begin
        w_svc_state_nxt = r_svc_state;
        w_beat_nxt      = r_beat;
        case (r_svc_state)
            c_svc_idle: begin
                if (!w_empty && !w_head.is_write && w_head.cnt == 8'd0) begin
                    w_svc_state_nxt = c_svc_burst;
                    w_beat_nxt      = 2'd0;
                end
            end
            c_svc_burst: begin
                w_beat_nxt = r_beat + 2'd1;
                if (r_beat == c_last_beat) w_svc_state_nxt = c_svc_idle;
            end
            default: w_svc_state_nxt = c_svc_idle;
        endcase
    end

    always_comb begin
        w_commit    = (r_svc_state == c_svc_idle) && !w_empty && w_head.is_write;
        w_pop       = w_commit || (r_svc_state == c_svc_burst && r_beat == c_last_beat);
        w_rd_idx    = {w_head.line[c_line_w-1:0], r_beat};
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        if (r_svc_state == c_svc_burst) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = {w_head.line, 5'b0};
            bmem_rdata  = r_mem[w_rd_idx];
        end
    end

    // A queued write lands all four words in a single cycle.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < BMEM_BURST_LEN; b++)
                r_mem[{w_head.line[c_line_w-1:0], 2'(b)}] <= w_head.data[b*BMEM_WORD_BITS +: BMEM_WORD_BITS];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmem_responder
// Brief    : Directed self-checking bench for bmem_responder.
// Revision : 1.0
// ============================================================================
module tb_bmem_responder;

    localparam int QDEPTH    = 4;
    localparam int READ_LAT  = 8;
    localparam int MEM_WORDS = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bmem_addr = '0;
    logic        bmem_read = 1'b0;
    logic        bmem_write = 1'b0;
    logic [63:0] bmem_wdata = '0;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    int n_vec = 0;
    int n_err = 0;

    bmem_responder #(
        .QDEPTH    (QDEPTH),
        .READ_LAT  (READ_LAT),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pre_word(input logic [31:0] a, input int b);
        return {16'hC0DE, a, 16'(b)};
    endfunction

    function automatic logic [255:0] pre_line(input logic [31:0] a);
        logic [255:0] d;
        for (int b = 0; b < 4; b++) d[b*64 +: 64] = pre_word(a, b);
        return d;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bmem_ready && n < 50) begin
            step();
            n++;
        end
        chk(tag, 64'(bmem_ready), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] d);
        wait_ready("wr_ready");
        bmem_write = 1'b1;
        bmem_addr  = a;
        bmem_wdata = d[63:0];
        step();
        for (int b = 1; b < 4; b++) begin
            bmem_wdata = d[b*64 +: 64];
            chk("wr_no_rvalid", 64'(bmem_rvalid), 64'd0);
            step();
        end
        bmem_write = 1'b0;
        bmem_wdata = '0;
    endtask

    task automatic do_read(input logic [31:0] a);
        wait_ready("rd_ready");
        bmem_read = 1'b1;
        bmem_addr = a;
        step();
        bmem_read = 1'b0;
    endtask

    // Waits for the next burst, reporting cycles waited, then checks all four beats.
    task automatic expect_burst(input string tag, input logic [31:0] a, input logic [255:0] d,
                                output int lat);
        int n = 0;
        while (!bmem_rvalid && n < 100) begin
            step();
            n++;
        end
        lat = n;
        chk({tag, "_seen"}, 64'(bmem_rvalid), 64'd1);
        for (int b = 0; b < 4; b++) begin
            chk({tag, "_rvalid"}, 64'(bmem_rvalid), 64'd1);
            chk({tag, "_raddr"}, 64'(bmem_raddr), 64'(a));
            chk({tag, "_rdata"}, bmem_rdata, d[b*64 +: 64]);
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        logic [255:0] d_abcd;
        logic [255:0] d_efgh;
        logic [255:0] d_x;

        d_abcd = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                  64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        d_efgh = {64'h4444_EEEE_0000_0008, 64'h3333_EEEE_0000_0007,
                  64'h2222_EEEE_0000_0006, 64'h1111_EEEE_0000_0005};
        d_x    = {64'h0, 64'h0, 64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};

        // Reset state
        step();
        step();
        chk("rst_ready", 64'(bmem_ready), 64'd0);
        chk("rst_rvalid", 64'(bmem_rvalid), 64'd0);
        chk("rst_raddr", 64'(bmem_raddr), 64'd0);
        chk("rst_rdata", bmem_rdata, 64'd0);
        rst = 1'b0;
        chk("rel_ready_low", 64'(bmem_ready), 64'd0);
        step();
        chk("rel_ready_high", 64'(bmem_ready), 64'd1);

        // Preload through the interface
        do_write(32'h0000_0040, pre_line(32'h0000_0040));
        do_write(32'h0000_0080, pre_line(32'h0000_0080));
        do_write(32'h0000_00C0, pre_line(32'h0000_00C0));
        do_write(32'h0000_0200, pre_line(32'h0000_0200));
        do_write(32'h0000_0300, pre_line(32'h0000_0300));
        repeat (4) step();

        // 1: single read on idle queue, ignored low address bits
        do_read(32'h0000_0047);
        expect_burst("t1", 32'h0000_0040, pre_line(32'h0000_0040), lat);
        chk("t1_latency", 64'(lat), 64'(READ_LAT));
        chk("t1_after", 64'(bmem_rvalid), 64'd0);

        // 2: write then read same line
        do_write(32'h0000_0100, d_abcd);
        do_read(32'h0000_0100);
        expect_burst("t2", 32'h0000_0100, d_abcd, lat);
        repeat (3) step();

        // 3: fill the queue with back-to-back reads
        bmem_read = 1'b1;
        for (int i = 0; i < QDEPTH; i++) begin
            chk("t3_issue_ready", 64'(bmem_ready), 64'd1);
            bmem_addr = 32'h40 * (i + 1);
            step();
        end
        bmem_read = 1'b0;
        chk("t3_full_ready", 64'(bmem_ready), 64'd0);
        expect_burst("t3a", 32'h0000_0040, pre_line(32'h0000_0040), lat);
        chk("t3_ready_after_pop", 64'(bmem_ready), 64'd1);
        expect_burst("t3b", 32'h0000_0080, pre_line(32'h0000_0080), lat);
        expect_burst("t3c", 32'h0000_00C0, pre_line(32'h0000_00C0), lat);
        expect_burst("t3d", 32'h0000_0100, d_abcd, lat);
        repeat (3) step();

        // 4: read / write / read ordering on one line
        do_read(32'h0000_0200);
        do_write(32'h0000_0200, d_efgh);
        do_read(32'h0000_0200);
        expect_burst("t4old", 32'h0000_0200, pre_line(32'h0000_0200), lat);
        expect_burst("t4new", 32'h0000_0200, d_efgh, lat);
        repeat (3) step();

        // 5: aborted write burst
        wait_ready("t5_ready");
        bmem_write = 1'b1;
        bmem_addr  = 32'h0000_0300;
        bmem_wdata = d_x[63:0];
        step();
        bmem_wdata = d_x[127:64];
        chk("t5_collect_ready", 64'(bmem_ready), 64'd0);
        step();
        bmem_write = 1'b0;
        bmem_wdata = '0;
        chk("t5_drop_ready", 64'(bmem_ready), 64'd0);
        step();
        chk("t5_idle_ready", 64'(bmem_ready), 64'd1);
        do_read(32'h0000_0300);
        expect_burst("t5", 32'h0000_0300, pre_line(32'h0000_0300), lat);
        chk("t5_latency", 64'(lat), 64'(READ_LAT));

        // 6: reset during beat 2 of a burst
        do_read(32'h0000_0040);
        seen = 0;
        while (!bmem_rvalid && seen < 100) begin
            step();
            seen++;
        end
        chk("t6_seen", 64'(bmem_rvalid), 64'd1);
        step();
        step();
        chk("t6_beat2", bmem_rdata, pre_word(32'h0000_0040, 2));
        rst = 1'b1;
        #1;
        chk("t6_rst_rvalid", 64'(bmem_rvalid), 64'd0);
        chk("t6_rst_raddr", 64'(bmem_raddr), 64'd0);
        chk("t6_rst_rdata", bmem_rdata, 64'd0);
        chk("t6_rst_ready", 64'(bmem_ready), 64'd0);
        step();
        step();
        rst = 1'b0;
        chk("t6_rel_ready_low", 64'(bmem_ready), 64'd0);
        step();
        chk("t6_rel_ready_high", 64'(bmem_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bmem_rvalid) seen++;
            step();
        end
        chk("t6_queue_flushed", 64'(seen), 64'd0);
        do_read(32'h0000_0080);
        expect_burst("t6post", 32'h0000_0080, pre_line(32'h0000_0080), lat);
        chk("t6_latency", 64'(lat), 64'(READ_LAT));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
